sdram_responder: RTL

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_if.sv | 27 ++
 rtl/sdram_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_if.sv
// Command/data bus between an SDRAM controller (master) and the responder model (slave).
interface sdram_if;
  logic        clock_enable;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [12:0] addr;
  logic [1:0]  bank_addr;
  logic        data_mask_low;
  logic        data_mask_high;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;

  modport master (
    output clock_enable, cs_n, ras_n, cas_n, we_n, addr, bank_addr,
    output data_mask_low, data_mask_high, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  clock_enable, cs_n, ras_n, cas_n, we_n, addr, bank_addr,
    input  data_mask_low, data_mask_high, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device: init sequence checker, 4-bank open-row tracking, small
// 16-bit storage, CAS-latency read pipeline and sticky protocol error flags.
module sdram_responder #(
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned CL_RESET = 3
) (
  input  logic       clk,
  input  logic       rst,
  sdram_if.slave     bus,
  output logic       init_done,
  output logic [3:0] err,
  output logic [7:0] refresh_count
);

  typedef enum logic [2:0] {StWaitPre, StRef1, StRef2, StWaitMrs, StReady} state_e;

  state_e state_q, state_d;

  logic        is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, any_cmd;
  logic        seq_err, init_pre, ref_ok, mrs_ok, ready;
  logic        act_ok, rd_ok, wr_ok, pre_ok, acc_closed, cl_valid;
  logic [3:0]  bank_open_q;
  logic [12:0] bank_row_q [4];
  logic [1:0]  cl_q;
  logic [3:0]  err_q;
  logic [7:0]  ref_cnt_q;
  logic [2:0]  slot_v_q;
  logic [1:0]  slot_cnt_q [3];
  logic [15:0] slot_data_q [3];
  logic        retire, free_ok;
  logic [1:0]  retire_idx, free_idx;
  logic        data_oe_q;
  logic [15:0] data_out_q;
  logic [15:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] mem_idx;
  logic        unused_row_hi;

  // Commands only exist on edges where the clock is enabled.
  always_comb begin
    {is_act, is_rd, is_wr, is_pre, is_ref, is_mrs} = '0;
    if (bus.clock_enable) begin
      case ({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n})
        4'b0011: is_act = 1'b1;
        4'b0101: is_rd  = 1'b1;
        4'b0100: is_wr  = 1'b1;
        4'b0010: is_pre = 1'b1;
        4'b0001: is_ref = 1'b1;
        4'b0000: is_mrs = 1'b1;
        default: ;
      endcase
    end
  end

  assign any_cmd = is_act | is_rd | is_wr | is_pre | is_ref | is_mrs;

  always_comb begin
    state_d  = state_q;
    seq_err  = 1'b0;
    init_pre = 1'b0;
    ref_ok   = 1'b0;
    mrs_ok   = 1'b0;
    unique case (state_q)
      StWaitPre: begin
        if (is_pre && bus.addr[10]) begin
          state_d  = StRef1;
          init_pre = 1'b1;
        end else if (any_cmd) begin
          seq_err = 1'b1;
        end
      end
      StRef1: begin
        if (is_ref) begin
          state_d = StRef2;
          ref_ok  = 1'b1;
        end else if (any_cmd) begin
          seq_err = 1'b1;
        end
      end
      StRef2: begin
        if (is_ref) begin
          state_d = StWaitMrs;
          ref_ok  = 1'b1;
        end else if (any_cmd) begin
          seq_err = 1'b1;
        end
      end
      StWaitMrs: begin
        if (is_mrs) begin
          state_d = StReady;
          mrs_ok  = 1'b1;
        end else if (any_cmd) begin
          seq_err = 1'b1;
        end
      end
      StReady: begin
        ref_ok = is_ref;
        mrs_ok = is_mrs;
      end
      default: state_d = StWaitPre;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWaitPre;
    end else if (bus.clock_enable) begin
      state_q <= state_d;
    end
  end

  assign ready      = (state_q == StReady);
  assign act_ok     = ready & is_act;
  assign rd_ok      = ready & is_rd & bank_open_q[bus.bank_addr];
  assign wr_ok      = ready & is_wr & bank_open_q[bus.bank_addr];
  assign acc_closed = ready & (is_rd | is_wr) & ~bank_open_q[bus.bank_addr];
  assign pre_ok     = init_pre | (ready & is_pre);
  assign cl_valid   = (bus.addr[6:4] == 3'd2) || (bus.addr[6:4] == 3'd3);
  // Row and column bits above [2:0] alias onto the same storage words.
  assign mem_idx    = MEM_AW'({bus.bank_addr, bank_row_q[bus.bank_addr][2:0], bus.addr[2:0]});
  assign unused_row_hi = ^{bank_row_q[0][12:3], bank_row_q[1][12:3],
                           bank_row_q[2][12:3], bank_row_q[3][12:3]};

  // A slot retiring this edge can be refilled on the same edge.
  always_comb begin
    retire     = 1'b0;
    retire_idx = '0;
    free_ok    = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < 3; i++) begin
      if (slot_v_q[i] && slot_cnt_q[i] == 2'd0) begin
        retire     = 1'b1;
        retire_idx = 2'(i);
      end
      if (!free_ok && (!slot_v_q[i] || slot_cnt_q[i] == 2'd0)) begin
        free_ok  = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open_q <= '0;
      for (int i = 0; i < 4; i++) bank_row_q[i] <= '0;
      cl_q       <= 2'(CL_RESET);
      err_q      <= '0;
      ref_cnt_q  <= '0;
      slot_v_q   <= '0;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
    end else if (bus.clock_enable) begin
      if (act_ok && !bank_open_q[bus.bank_addr]) begin
        bank_open_q[bus.bank_addr] <= 1'b1;
        bank_row_q[bus.bank_addr]  <= bus.addr;
      end
      if (pre_ok) begin
        if (bus.addr[10]) bank_open_q <= '0;
        else              bank_open_q[bus.bank_addr] <= 1'b0;
      end
      if (mrs_ok && cl_valid) cl_q <= bus.addr[5:4];
      err_q <= err_q | {ref_ok & (|bank_open_q),
                        seq_err | (mrs_ok & ~cl_valid),
                        acc_closed,
                        act_ok & bank_open_q[bus.bank_addr]};
      if (ref_ok && ref_cnt_q != 8'hFF) ref_cnt_q <= ref_cnt_q + 8'd1;

      for (int i = 0; i < 3; i++) begin
        if (slot_v_q[i]) begin
          if (slot_cnt_q[i] == 2'd0) slot_v_q[i] <= 1'b0;
          else                       slot_cnt_q[i] <= slot_cnt_q[i] - 2'd1;
        end
      end
      if (rd_ok && free_ok) begin
        slot_v_q[free_idx]    <= 1'b1;
        slot_cnt_q[free_idx]  <= cl_q - 2'd1;
        slot_data_q[free_idx] <= mem[mem_idx];
      end
      data_oe_q  <= retire;
      data_out_q <= retire ? slot_data_q[retire_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      if (!bus.data_mask_low)  mem[mem_idx][7:0]  <= bus.data_in[7:0];
      if (!bus.data_mask_high) mem[mem_idx][15:8] <= bus.data_in[15:8];
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;
  assign init_done     = ready;
  assign err           = err_q;
  assign refresh_count = ref_cnt_q;

endmodule
